// File: rtl/gamma_scheduler.sv
// Gamma-cycle sequencer: fetches one packed spike-time sample per step, sweeps the layer through
// one gamma period, then hands the winning neuron out on a valid/ready result port.
module gamma_scheduler #(
    parameter int TIME_PERIOD = 16,
    parameter int TIME_W      = 5,
    parameter int NEURON_W    = 5,
    parameter int ADDR_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                train_mode,
    input  logic [ADDR_W-1:0]   num_samples,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_rvalid,
    input  logic [31:0]         mem_rdata,
    output logic [31:0]         spike_times,
    output logic [TIME_W-1:0]   time_val,
    output logic                layer_clr,
    output logic                layer_en,
    output logic                training,
    input  logic [NEURON_W-1:0] winner_in,
    input  logic [TIME_W-1:0]   win_time_in,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [NEURON_W-1:0] result_neuron,
    output logic [TIME_W-1:0]   result_time,
    output logic [ADDR_W-1:0]   result_idx,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_CLEAR, S_RUN, S_CAPTURE, S_HOLD, S_DONE
    } state_t;

    localparam logic [TIME_W-1:0] LAST_T = TIME_W'(TIME_PERIOD - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_num_samples;
    logic                r_train_mode;
    logic                r_mem_req;
    logic [31:0]         r_spike_times;
    logic [TIME_W-1:0]   r_time_val;
    logic                r_layer_clr;
    logic                r_layer_en;
    logic                r_training;
    logic                r_result_valid;
    logic [NEURON_W-1:0] r_result_neuron;
    logic [TIME_W-1:0]   r_result_time;
    logic [ADDR_W-1:0]   r_result_idx;
    logic                r_done;

    // One extra bit so the last-sample compare cannot alias when idx+1 reaches 2^ADDR_W.
    logic [ADDR_W:0]     w_idx_inc;
    logic                w_last_sample;

    assign w_idx_inc     = {1'b0, r_idx} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last_sample = (w_idx_inc == {1'b0, r_num_samples});

    // Pulse outputs default low each cycle and are set on the transition into their state,
    // so every output is a flop aligned with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_num_samples   <= '0;
            r_train_mode    <= 1'b0;
            r_mem_req       <= 1'b0;
            r_spike_times   <= '0;
            r_time_val      <= '0;
            r_layer_clr     <= 1'b0;
            r_layer_en      <= 1'b0;
            r_training      <= 1'b0;
            r_result_valid  <= 1'b0;
            r_result_neuron <= '0;
            r_result_time   <= '0;
            r_result_idx    <= '0;
            r_done          <= 1'b0;
        end else begin
            r_mem_req   <= 1'b0;
            r_layer_clr <= 1'b0;
            r_done      <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_state        <= S_IDLE;
                r_layer_en     <= 1'b0;
                r_training     <= 1'b0;
                r_result_valid <= 1'b0;
                r_time_val     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_num_samples <= num_samples;
                            r_train_mode  <= train_mode;
                            r_idx         <= '0;
                            if (num_samples == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state   <= S_LOAD;
                                r_mem_req <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (mem_rvalid) begin
                            r_spike_times <= mem_rdata;
                            r_state       <= S_CLEAR;
                            r_layer_clr   <= 1'b1;
                            r_time_val    <= '0;
                        end
                    end
                    S_CLEAR: begin
                        r_state    <= S_RUN;
                        r_layer_en <= 1'b1;
                        r_training <= r_train_mode;
                        r_time_val <= '0;
                    end
                    S_RUN: begin
                        if (r_time_val == LAST_T) begin
                            r_state    <= S_CAPTURE;
                            r_layer_en <= 1'b0;
                            r_training <= 1'b0;
                            r_time_val <= '0;
                        end else begin
                            r_time_val <= r_time_val + TIME_W'(1);
                        end
                    end
                    S_CAPTURE: begin
                        r_result_neuron <= winner_in;
                        r_result_time   <= win_time_in;
                        r_result_idx    <= r_idx;
                        r_result_valid  <= 1'b1;
                        r_state         <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (result_ready) begin
                            r_result_valid <= 1'b0;
                            r_idx          <= w_idx_inc[ADDR_W-1:0];
                            if (w_last_sample) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state   <= S_LOAD;
                                r_mem_req <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_req       = r_mem_req;
    assign mem_addr      = r_idx;
    assign spike_times   = r_spike_times;
    assign time_val      = r_time_val;
    assign layer_clr     = r_layer_clr;
    assign layer_en      = r_layer_en;
    assign training      = r_training;
    assign result_valid  = r_result_valid;
    assign result_neuron = r_result_neuron;
    assign result_time   = r_result_time;
    assign result_idx    = r_result_idx;
    assign done          = r_done;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_gamma_scheduler.sv
// Scoreboard bench for gamma_scheduler: stimulus pushes expected requests, samples and results;
// a negedge monitor pops and compares them as the DUT presents each event.
module tb_gamma_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, abort, train_mode;
    logic [7:0]  num_samples;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] spike_times;
    logic [4:0]  time_val;
    logic        layer_clr, layer_en, training;
    logic [4:0]  winner_in, win_time_in;
    logic        result_valid, result_ready;
    logic [4:0]  result_neuron, result_time;
    logic [7:0]  result_idx;
    logic        busy, done;

    logic        mem_rvalid_m, inj_valid;
    logic [31:0] mem_rdata_m, inj_data;

    assign mem_rvalid = mem_rvalid_m | inj_valid;
    assign mem_rdata  = inj_valid ? inj_data : mem_rdata_m;

    always #5 clk = ~clk;

    gamma_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .train_mode(train_mode),
        .num_samples(num_samples), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .spike_times(spike_times),
        .time_val(time_val), .layer_clr(layer_clr), .layer_en(layer_en), .training(training),
        .winner_in(winner_in), .win_time_in(win_time_in), .result_valid(result_valid),
        .result_ready(result_ready), .result_neuron(result_neuron), .result_time(result_time),
        .result_idx(result_idx), .busy(busy), .done(done)
    );

    typedef struct {
        logic [4:0] n;
        logic [4:0] t;
        logic [7:0] idx;
        bit         last;
    } res_t;

    logic [31:0] mem_data [0:1];
    logic [4:0]  lay_n [0:1];
    logic [4:0]  lay_t [0:1];

    logic [7:0]  exp_req [$];
    logic [31:0] exp_spk [$];
    res_t        exp_res [$];
    int          exp_done [$];

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          req_due = -1;
    int          en_cnt = 0;
    int          en_total = 0;
    logic        cur_train = 1'b0;
    logic [31:0] cur_spk = '0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        mem_data[0] = 32'hA5A5_0F0F;  mem_data[1] = 32'h1234_5678;
        lay_n[0] = 5'd3;  lay_t[0] = 5'd9;
        lay_n[1] = 5'd17; lay_t[1] = 5'd2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic bad(input string name);
        n_chk++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    // Memory + layer stub: data returns 3 cycles after the request; the stub's winner follows the sample.
    initial begin : mem_model
        logic [7:0] a;
        mem_rvalid_m = 1'b0; mem_rdata_m = '0; winner_in = '0; win_time_in = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                a = mem_addr;
                repeat (3) @(posedge clk);
                #1;
                mem_rvalid_m = 1'b1;
                mem_rdata_m  = mem_data[a[0]];
                winner_in    = lay_n[a[0]];
                win_time_in  = lay_t[a[0]];
                @(posedge clk);
                #1 mem_rvalid_m = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [7:0]  a;
        logic [31:0] s;
        res_t        r;
        int          d;
        forever begin
            @(negedge clk);
            if (layer_en === 1'b1) begin
                chk("time_val step", 32'(time_val), 32'(en_cnt));
                chk("training in run", 32'(training), 32'(cur_train));
                en_cnt++;
                en_total++;
            end else begin
                chk("training outside run", 32'(training), 32'd0);
            end
            if (layer_clr === 1'b1) begin
                chk("time_val at clear", 32'(time_val), 32'd0);
                en_cnt = 0;
                if (exp_spk.size() > 0) begin
                    s = exp_spk.pop_front();
                    chk("spike_times", spike_times, s);
                    cur_spk = s;
                end else bad("unexpected layer_clr");
            end
            if (mem_req === 1'b1) begin
                if (exp_req.size() > 0) begin
                    a = exp_req.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(a));
                    if (req_due >= 0) chk("req after handshake", 32'(cyc), 32'(req_due));
                    req_due = -1;
                end else bad("unexpected mem_req");
            end
            if (result_valid === 1'b1 && result_ready === 1'b1) begin
                if (exp_res.size() > 0) begin
                    r = exp_res.pop_front();
                    $display("result idx=%0d neuron=%0d time=%0d cycle=%0d",
                             result_idx, result_neuron, result_time, cyc);
                    chk("result_neuron", 32'(result_neuron), 32'(r.n));
                    chk("result_time", 32'(result_time), 32'(r.t));
                    chk("result_idx", 32'(result_idx), 32'(r.idx));
                    chk("layer_en cycles", 32'(en_cnt), 32'd16);
                    chk("spike_times held", spike_times, cur_spk);
                    if (r.last) exp_done.push_back(cyc + 1);
                    else req_due = cyc + 1;
                end else bad("unexpected result");
            end
            if (done === 1'b1) begin
                if (exp_done.size() > 0) begin
                    d = exp_done.pop_front();
                    chk("done cycle", 32'(cyc), 32'(d));
                end else bad("unexpected done");
            end
        end
    end

    task automatic push_sample(input int i, input bit last);
        res_t r;
        r.n = lay_n[i]; r.t = lay_t[i]; r.idx = 8'(i); r.last = last;
        exp_req.push_back(8'(i));
        exp_spk.push_back(mem_data[i]);
        exp_res.push_back(r);
    endtask

    task automatic start_run(input logic [7:0] n, input logic tm);
        @(posedge clk);
        #1;
        start = 1'b1; num_samples = n; train_mode = tm; cur_train = tm;
        if (n == 8'd0) exp_done.push_back(cyc + 1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin found = 1'b1; break; end
        end
        chk({name, " reaches idle"}, 32'(found), 32'd1);
        chk({name, " queues drained"},
            32'(exp_req.size() + exp_spk.size() + exp_res.size() + exp_done.size()), 32'd0);
    endtask

    task automatic wait_time(input logic [4:0] tv);
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (layer_en === 1'b1 && time_val === tv) begin found = 1'b1; break; end
        end
        chk("reach time_val", 32'(found), 32'd1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " spike_times"}, spike_times, 32'd0);
        chk({name, " time_val"}, 32'(time_val), 32'd0);
        chk({name, " pulses"}, {27'd0, mem_req, layer_clr, layer_en, done, result_valid}, 32'd0);
        chk({name, " result"}, {11'd0, result_neuron, result_time, result_idx}, 32'd0);
    endtask

    initial begin : stimulus
        bit         found;
        int         en_before;
        logic [4:0] h_n, h_t;
        logic [7:0] h_i;
        rst = 1'b1; start = 1'b0; abort = 1'b0; train_mode = 1'b0; num_samples = '0;
        result_ready = 1'b1; inj_valid = 1'b0; inj_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Single sample, training on.
        push_sample(0, 1'b1);
        start_run(8'd1, 1'b1);
        wait_idle("single");

        // Two samples with 5 cycles of result backpressure.
        result_ready = 1'b0;
        push_sample(0, 1'b0);
        push_sample(1, 1'b1);
        start_run(8'd2, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin found = 1'b1; break; end
        end
        chk("result_valid seen", 32'(found), 32'd1);
        h_n = result_neuron; h_t = result_time; h_i = result_idx;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("held valid", 32'(result_valid), 32'd1);
            chk("held result", {17'd0, result_neuron, result_time, result_idx},
                {17'd0, lay_n[0], lay_t[0], 8'd0});
            chk("held stable", {17'd0, result_neuron, result_time, result_idx}, {17'd0, h_n, h_t, h_i});
        end
        @(posedge clk);
        #1 result_ready = 1'b1;
        wait_idle("backpressure");

        // Zero samples: straight to done, no fetch, no layer activity.
        en_before = en_total;
        start_run(8'd0, 1'b1);
        wait_idle("zero");
        chk("zero layer_en", 32'(en_total), 32'(en_before));

        // Abort mid-gamma-cycle, then a fresh run must still be accepted.
        exp_req.push_back(8'd0);
        exp_spk.push_back(mem_data[0]);
        start_run(8'd1, 1'b1);
        wait_time(5'd7);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort pulses", {27'd0, mem_req, layer_clr, layer_en, done, result_valid}, 32'd0);
        repeat (5) @(negedge clk);
        chk("abort stays idle", 32'(busy), 32'd0);
        push_sample(0, 1'b1);
        start_run(8'd1, 1'b0);
        wait_idle("after abort");

        // start and a stray read-valid during RUN are both ignored.
        push_sample(1, 1'b1);
        exp_req[0] = 8'd0;
        exp_spk[0] = mem_data[0];
        exp_res[0].n = lay_n[0]; exp_res[0].t = lay_t[0]; exp_res[0].idx = 8'd0;
        start_run(8'd1, 1'b1);
        wait_time(5'd3);
        start = 1'b1; num_samples = 8'd5; train_mode = 1'b0;
        inj_valid = 1'b1; inj_data = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0; inj_valid = 1'b0;
        @(negedge clk);
        chk("spike_times after stray rvalid", spike_times, mem_data[0]);
        wait_idle("ignored events");
        repeat (4) @(negedge clk);
        chk("no restart from ignored start", 32'(busy), 32'd0);

        // Reset in the middle of RUN.
        exp_req.push_back(8'd0);
        exp_spk.push_back(mem_data[0]);
        start_run(8'd1, 1'b1);
        wait_time(5'd9);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("mid-run reset");
        req_due = -1;
        repeat (3) @(negedge clk);
        chk("reset queues drained",
            32'(exp_req.size() + exp_spk.size() + exp_res.size() + exp_done.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
